// File: rtl/putb_rmw.sv
// putb_rmw: byte store into a word-wide memory via read-modify-write.
// Reads the addressed word, merges one byte lane, writes it back, pulses done.
module putb_rmw #(
    parameter int WIDTH = 32,
    parameter int AW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    addr,
    input  logic [1:0]       byte_idx,
    input  logic [7:0]       wbyte,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_n;

    logic [1:0] lat_idx;
    logic [7:0] lat_byte;

    // Replace exactly one lane; all other bits pass through untouched.
    function automatic logic [WIDTH-1:0] merge(
        input logic [WIDTH-1:0] w,
        input logic [1:0]       idx,
        input logic [7:0]       b
    );
        logic [WIDTH-1:0] r;
        r = w;
        unique case (idx)
            2'd0: r[7:0]   = b;
            2'd1: r[15:8]  = b;
            2'd2: r[23:16] = b;
            2'd3: r[31:24] = b;
            default: r = w;
        endcase
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: one read, one write, one done cycle per store.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = RD;
            RD:   if (mem_ack) state_n = WR;
            WR:   if (mem_ack) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs and latched request fields.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            res       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_idx   <= '0;
            lat_byte  <= '0;
        end else begin
            busy    <= (state_n != IDLE);
            done    <= (state_n == DONE);
            mem_req <= (state_n == RD) || (state_n == WR);
            mem_we  <= (state_n == WR);
            if (state == IDLE && start) begin
                mem_addr <= addr;
                lat_idx  <= byte_idx;
                lat_byte <= wbyte;
            end
            if (state == RD && mem_ack) begin
                mem_wdata <= merge(mem_rdata, lat_idx, lat_byte);
            end
            if (state == WR && mem_ack) begin
                res <= mem_wdata;
            end
        end
    end

endmodule
